// File: rtl/spiking_neuron_layer_param.sv
// Layer of N_OUT leaky integrate-and-fire neurons fully connected to N_IN shared spike inputs.
// Weights live in an internal register file. Membrane arithmetic saturates.
module spiking_neuron_layer_param #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3,
  parameter int WW    = 8,
  parameter int VW    = 10,
  localparam int NW   = N_IN * N_OUT,
  localparam int AW   = (NW > 1) ? $clog2(NW) : 1,
  localparam int SW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_IN-1:0]   input_spikes,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WW-1:0]     wr_data,
  input  logic [7:0]        threshold,
  input  logic [7:0]        decay,
  input  logic [7:0]        refractory_period,
  input  logic [7:0]        feedback_scale,
  input  logic [SW-1:0]     mon_sel,
  output logic [N_OUT-1:0]  spike_out,
  output logic [VW-1:0]     mon_potential
);

  localparam int CW = WW + $clog2(N_IN) + 1;
  localparam int PW = VW + 9;
  localparam int EW = VW + 2;

  logic signed [WW-1:0] w_q   [NW];
  logic signed [WW-1:0] w_d   [NW];
  logic signed [VW-1:0] v_q   [N_OUT];
  logic signed [VW-1:0] v_d   [N_OUT];
  logic [7:0]           ref_q [N_OUT];
  logic [7:0]           ref_d [N_OUT];
  logic [N_OUT-1:0]     spike_q;
  logic [N_OUT-1:0]     spike_d;

  logic signed [CW-1:0] cur_acc [N_OUT];
  logic signed [WW-1:0] cur_sat [N_OUT];
  logic signed [PW-1:0] prod    [N_OUT];
  logic signed [EW-1:0] leak    [N_OUT];
  logic signed [EW-1:0] fb      [N_OUT];
  logic signed [EW-1:0] v_sum   [N_OUT];
  logic signed [VW-1:0] v_sat   [N_OUT];
  logic signed [EW-1:0] thr_ext;

  assign thr_ext   = $signed(EW'(threshold));
  assign spike_out = spike_q;

  // Out-of-range addresses simply match no entry.
  always_comb begin
    for (int a = 0; a < NW; a++) begin
      w_d[a] = w_q[a];
      if (wr_en && (int'(wr_addr) == a)) w_d[a] = wr_data;
    end
  end

  always_comb begin
    spike_d = spike_q;
    for (int k = 0; k < N_OUT; k++) begin
      v_d[k]     = v_q[k];
      ref_d[k]   = ref_q[k];
      cur_acc[k] = '0;
      for (int i = 0; i < N_IN; i++)
        if (input_spikes[i]) cur_acc[k] = cur_acc[k] + CW'(w_q[k*N_IN+i]);

      if (cur_acc[k][CW-1:WW-1] == {(CW-WW+1){cur_acc[k][CW-1]}})
        cur_sat[k] = cur_acc[k][WW-1:0];
      else
        cur_sat[k] = cur_acc[k][CW-1] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};

      // Arithmetic shift of the signed product floors toward -inf.
      prod[k]  = PW'(v_q[k]) * PW'($signed({1'b0, decay}));
      leak[k]  = EW'(prod[k] >>> 8);
      fb[k]    = spike_q[k] ? EW'($signed(feedback_scale)) : '0;
      v_sum[k] = EW'(v_q[k]) - leak[k] + EW'(cur_sat[k]) + fb[k];

      if (v_sum[k][EW-1:VW-1] == {(EW-VW+1){v_sum[k][EW-1]}})
        v_sat[k] = v_sum[k][VW-1:0];
      else
        v_sat[k] = v_sum[k][EW-1] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};

      if (enable) begin
        if (ref_q[k] != 8'd0) begin
          ref_d[k]   = ref_q[k] - 8'd1;
          v_d[k]     = '0;
          spike_d[k] = 1'b0;
        end else if (v_sum[k] >= thr_ext) begin
          spike_d[k] = 1'b1;
          v_d[k]     = '0;
          ref_d[k]   = refractory_period;
        end else begin
          spike_d[k] = 1'b0;
          v_d[k]     = v_sat[k];
        end
      end
    end
  end

  always_comb begin
    mon_potential = '0;
    for (int k = 0; k < N_OUT; k++)
      if (int'(mon_sel) == k) mon_potential = v_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NW; a++) w_q[a] <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        v_q[k]   <= '0;
        ref_q[k] <= '0;
      end
      spike_q <= '0;
    end else begin
      for (int a = 0; a < NW; a++) w_q[a] <= w_d[a];
      for (int k = 0; k < N_OUT; k++) begin
        v_q[k]   <= v_d[k];
        ref_q[k] <= ref_d[k];
      end
      spike_q <= spike_d;
    end
  end

endmodule
